// File: rtl/axi4_lite_master.sv
// AXI4-Lite master that turns single user commands into one AXI read or write
// transaction at a time and returns the completion on a rsp_* handshake.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,

  // User command / response side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,

  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,

  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY,

  // Current FSM state, for checkers and debug
  output logic [2:0]              dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid && ready; a raised valid and its payload hold until that edge, and no
  // valid or ready driven here is a combinational function of the peer's signal.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  arvalid_q,   arvalid_d;
  logic                  bready_q,    bready_d;
  logic                  rready_q,    rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,    araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q,  rsp_resp_d;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; leave once both have been taken.
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        if (BVALID && bready_q) begin
          rsp_resp_d  = BRESP;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end

      RD_REQ: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (RVALID && rready_q) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Per-state strobes are registered from the next state so they line up with it.
    cmd_ready_d = (state_d == IDLE);
    bready_d    = (state_d == WR_RESP);
    rready_d    = (state_d == RD_DATA);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: a delay-configurable AXI4-Lite slave model
// plus user-side command/response tasks with hand-computed expectations.
`timescale 1ns/1ps
module tb_axi4_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd1;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic [2:0]    dbg_state;

  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int            aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic          b_enable = 1'b1;
  logic [1:0]    b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [DW-1:0] r_data_cfg = '0;

  int            aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_hi, w_hi, ar_hi;
  int            aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc;
  logic [AW-1:0] aw_addr_seen, ar_addr_seen;
  logic [DW-1:0] wdata_seen;
  logic [SW-1:0] wstrb_seen;
  logic          unstable;

  logic          aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic          aw_done, w_done, ar_done;
  logic          aw_pend, w_pend, ar_pend;
  int            aw_cnt, w_cnt, ar_cnt;
  logic [AW-1:0] aw_prev, ar_prev;
  logic [DW-1:0] wd_prev;
  logic [SW-1:0] ws_prev;

  task automatic clear_obs();
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_hs_cyc = -1; w_hs_cyc = -1; b_hs_cyc = -1; ar_hs_cyc = -1;
    aw_addr_seen = '1; ar_addr_seen = '1; wdata_seen = '1; wstrb_seen = '1;
    unstable = 1'b0;
  endtask

  task automatic slave_reset();
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0; ar_fire = 1'b0; r_fire = 1'b0;
    aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
  endtask

  // Runs 2 ns after each edge: records what fired on that edge, then sets up the next one.
  initial begin
    clear_obs();
    slave_reset();
    forever begin
      @(posedge ACLK); #2;
      if (!ARESETn) begin
        slave_reset();
      end else begin
        if (aw_fire) begin aw_done = 1'b1; aw_hs++; aw_hs_cyc = cyc; end
        if (w_fire)  begin w_done  = 1'b1; w_hs++;  w_hs_cyc  = cyc; end
        if (ar_fire) begin ar_done = 1'b1; ar_hs++; ar_hs_cyc = cyc; end
        if (b_fire)  begin BVALID = 1'b0; b_hs++; b_hs_cyc = cyc; end
        if (r_fire)  begin RVALID = 1'b0; r_hs++; end
        if (b_enable && aw_done && w_done && !BVALID) begin
          BVALID = 1'b1; BRESP = b_resp_cfg; aw_done = 1'b0; w_done = 1'b0;
        end
        if (ar_done && !RVALID) begin
          RVALID = 1'b1; RDATA = r_data_cfg; RRESP = r_resp_cfg; ar_done = 1'b0;
        end
        if ((aw_pend && (!AWVALID || AWADDR != aw_prev)) ||
            (w_pend && (!WVALID || WDATA != wd_prev || WSTRB != ws_prev)) ||
            (ar_pend && (!ARVALID || ARADDR != ar_prev)))
          unstable = 1'b1;
        if (AWVALID) begin aw_hi++; AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin AWREADY = 1'b0; aw_cnt = 0; end
        if (WVALID) begin w_hi++; WREADY = (w_cnt >= w_delay); w_cnt++; end
        else begin WREADY = 1'b0; w_cnt = 0; end
        if (ARVALID) begin ar_hi++; ARREADY = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin ARREADY = 1'b0; ar_cnt = 0; end
        aw_fire = AWVALID && AWREADY;
        w_fire  = WVALID && WREADY;
        ar_fire = ARVALID && ARREADY;
        b_fire  = BVALID && BREADY;
        r_fire  = RVALID && RREADY;
        if (aw_fire) aw_addr_seen = AWADDR;
        if (w_fire) begin wdata_seen = WDATA; wstrb_seen = WSTRB; end
        if (ar_fire) ar_addr_seen = ARADDR;
        aw_pend = AWVALID && !aw_fire; aw_prev = AWADDR;
        w_pend  = WVALID && !w_fire;   wd_prev = WDATA; ws_prev = WSTRB;
        ar_pend = ARVALID && !ar_fire; ar_prev = ARADDR;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                           output int acc_cyc);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check_eq("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    check_eq("state_after_accept", dbg_state, wr ? S_WR_REQ : S_RD_REQ);
    check_eq("cmd_ready_after_accept", cmd_ready, 1'b0);
  endtask

  task automatic wait_rsp(output int rcyc);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    check_eq("rsp_valid_seen", rsp_valid, 1'b1);
    rcyc = cyc;
  endtask

  task automatic consume_rsp(input logic exp_write, input logic [1:0] exp_resp);
    logic [DW-1:0] exp_data;
    exp_data = '1;
    if (exp_q.size() > 0) exp_data = exp_q.pop_front();
    check_eq("rsp_write", rsp_write, exp_write);
    check_eq("rsp_rdata", rsp_rdata, exp_data);
    check_eq("rsp_resp", rsp_resp, exp_resp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_consume", rsp_valid, 1'b0);
    check_eq("cmd_ready_after_consume", cmd_ready, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc, rcyc;
    logic saw_rsp;

    // Reset held: everything low.
    repeat (3) tick();
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 6'b0);
    check_eq("rst_payload", {AWADDR, ARADDR, WDATA, WSTRB, rsp_resp, rsp_write}, '0);
    check_eq("rst_rsp_rdata", rsp_rdata, '0);
    check_eq("rst_state", dbg_state, S_IDLE);
    ARESETn = 1'b1;
    tick();
    check_eq("cmd_ready_first_cycle", cmd_ready, 1'b1);

    // Zero-wait write.
    phase = "wr_zero_wait";
    clear_obs(); aw_delay = 0; w_delay = 0; b_resp_cfg = 2'b00;
    exp_q.push_back('0);
    issue_cmd(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, acc);
    check_eq("awvalid_wvalid_up", {AWVALID, WVALID}, 2'b11);
    wait_rsp(rcyc);
    check_eq("rsp_latency", rcyc - acc, 2);
    consume_rsp(1'b1, 2'b00);
    check_eq("aw_addr", aw_addr_seen, 32'h0);
    check_eq("w_data", wdata_seen, 32'hA5A5_A5A5);
    check_eq("w_strb", wstrb_seen, 4'hF);
    check_eq("hs_counts", {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0]}, 16'h1110);
    check_eq("aw_hs_cycle", aw_hs_cyc - acc, 1);
    check_eq("b_hs_cycle", b_hs_cyc - acc, 2);
    check_eq("stable", unstable, 1'b0);

    // Read with ARREADY held off 3 cycles.
    phase = "rd_ar_delay";
    clear_obs(); ar_delay = 3; r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b00;
    exp_q.push_back(32'hDEAD_BEEF);
    issue_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, acc);
    wait_rsp(rcyc);
    check_eq("rsp_latency", rcyc - acc, 5);
    consume_rsp(1'b0, 2'b00);
    check_eq("ar_valid_cycles", ar_hi, 4);
    check_eq("ar_addr", ar_addr_seen, 32'h4);
    check_eq("ar_hs_cycle", ar_hs_cyc - acc, 4);
    check_eq("r_hs", r_hs, 1);
    check_eq("no_write_traffic", aw_hi + w_hi, 0);
    check_eq("stable", unstable, 1'b0);

    // AW first, W three cycles later; slave reports SLVERR.
    phase = "wr_aw_first";
    clear_obs(); aw_delay = 0; w_delay = 3; b_resp_cfg = 2'b10;
    exp_q.push_back('0);
    issue_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, acc);
    wait_rsp(rcyc);
    check_eq("rsp_latency", rcyc - acc, 5);
    consume_rsp(1'b1, 2'b10);
    check_eq("aw_valid_cycles", aw_hi, 1);
    check_eq("w_valid_cycles", w_hi, 4);
    check_eq("w_hs_cycle", w_hs_cyc - acc, 4);
    check_eq("b_hs", b_hs, 1);
    check_eq("w_strb", wstrb_seen, 4'h3);
    check_eq("stable", unstable, 1'b0);

    // W first, AW three cycles later.
    phase = "wr_w_first";
    clear_obs(); aw_delay = 3; w_delay = 0; b_resp_cfg = 2'b00;
    exp_q.push_back('0);
    issue_cmd(1'b1, 32'h0000_0014, 32'h8765_4321, 4'hC, acc);
    wait_rsp(rcyc);
    check_eq("rsp_latency", rcyc - acc, 5);
    consume_rsp(1'b1, 2'b00);
    check_eq("aw_valid_cycles", aw_hi, 4);
    check_eq("w_valid_cycles", w_hi, 1);
    check_eq("aw_addr", aw_addr_seen, 32'h14);
    check_eq("b_hs", b_hs, 1);
    check_eq("stable", unstable, 1'b0);

    // Zero-wait read returning DECERR.
    phase = "rd_decerr";
    clear_obs(); ar_delay = 0; r_data_cfg = 32'h0BAD_F00D; r_resp_cfg = 2'b11;
    exp_q.push_back(32'h0BAD_F00D);
    issue_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, acc);
    wait_rsp(rcyc);
    check_eq("rsp_latency", rcyc - acc, 2);
    consume_rsp(1'b0, 2'b11);
    check_eq("ar_valid_cycles", ar_hi, 1);

    // Completion held by rsp_ready=0 while a new command waits.
    phase = "rsp_backpressure";
    clear_obs(); r_resp_cfg = 2'b00; b_resp_cfg = 2'b01;
    issue_cmd(1'b1, 32'h0000_0020, 32'h0000_0055, 4'h1, acc);
    wait_rsp(rcyc);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("held_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1101);
      check_eq("held_rdata", rsp_rdata, '0);
      check_eq("held_no_new_req", {cmd_ready, AWVALID, WVALID, ARVALID}, 4'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("released_idle", {rsp_valid, cmd_ready}, 2'b01);
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    check_eq("pending_cmd_taken", dbg_state, S_RD_REQ);
    check_eq("pending_araddr", {ARVALID, ARADDR}, {1'b1, 32'h0000_0040});
    r_data_cfg = 32'h0000_0077;
    exp_q.push_back(32'h0000_0077);
    wait_rsp(rcyc);
    check_eq("rsp_latency", rcyc - acc, 2);
    consume_rsp(1'b0, 2'b00);

    // Reset while waiting in WR_RESP.
    phase = "reset_in_wr_resp";
    clear_obs(); b_enable = 1'b0; aw_delay = 0; w_delay = 0;
    issue_cmd(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, acc);
    for (int i = 0; i < 20 && !BREADY; i++) tick();
    check_eq("in_wr_resp", {BREADY, dbg_state}, {1'b1, S_WR_RESP});
    ARESETn = 1'b0;
    tick();
    check_eq("abort_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready}, 7'b0);
    check_eq("abort_payload", {AWADDR, WDATA, WSTRB}, '0);
    check_eq("abort_state", dbg_state, S_IDLE);
    b_enable = 1'b1;
    ARESETn = 1'b1;
    tick();
    check_eq("cmd_ready_after_release", cmd_ready, 1'b1);
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) saw_rsp = 1'b1;
      tick();
    end
    check_eq("no_completion_after_abort", saw_rsp, 1'b0);
    check_eq("b_never_taken", b_hs, 0);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 or 64); strobe width DATA_WIDTH/8.
REQ-003 SHALL use one clock and a synchronous, active-low reset: ports ACLK and ARESETn.
REQ-004 ACLK  in  1  clock; all logic on rising edge.
REQ-005 ARESETn  in  1  synchronous active-low reset.
REQ-006 cmd_valid  in  1  user command request.
REQ-007 cmd_ready  out  1  command accepted on edge where cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  out  1  completion available.
REQ-013 rsp_ready  in  1  user consumes completion.
REQ-014 rsp_write  out  1  completion belongs to a write.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-016 rsp_resp  out  2  captured BRESP or RRESP.
REQ-017 AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out: standard AXI4-Lite master ports, widths per ADDR_WIDTH/DATA_WIDTH, BRESP/RRESP 2 bits.

Function
REQ-018 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; one transaction outstanding at a time.
REQ-019 cmd_ready SHALL be 1 only in IDLE (registered, not combinational from cmd_valid).
REQ-020 On accept, addr/wdata/wstrb SHALL be registered; write -> WR_REQ with AWVALID=1 and WVALID=1 from the next cycle; read -> RD_REQ with ARVALID=1 from the next cycle.
REQ-021 In WR_REQ, AWVALID and WVALID SHALL each deassert on the edge of their own handshake, independently; either may complete first or both on the same edge.
REQ-022 WR_REQ SHALL move to WR_RESP on the edge where the last of AW/W handshakes completes; BREADY SHALL be 1 only in WR_RESP.
REQ-023 On BVALID && BREADY edge: rsp_resp <= BRESP, rsp_write <= 1, rsp_rdata <= 0, go RSP.
REQ-024 In RD_REQ, ARVALID SHALL deassert on ARVALID && ARREADY edge and go RD_DATA; RREADY SHALL be 1 only in RD_DATA.
REQ-025 On RVALID && RREADY edge: rsp_rdata <= RDATA, rsp_resp <= RRESP, rsp_write <= 0, go RSP.
REQ-026 In RSP, rsp_valid SHALL be 1 and rsp_* stable until rsp_valid && rsp_ready edge, then IDLE.
REQ-027 While any AXI VALID is 1 and not handshaken, its address/data/strobe SHALL remain stable; VALID SHALL never depend combinationally on READY.
REQ-028 BVALID/RVALID arriving outside WR_RESP/RD_DATA SHALL be ignored (READY low); no timeout, module waits indefinitely.
REQ-029 Zero-wait slave (READYs tied 1, response next cycle) SHALL give: write accept edge N -> AW/W handshake N+1 -> B handshake N+2 earliest -> rsp_valid from N+2; read: AR N+1, R N+2 earliest.
REQ-030 cmd_valid in non-IDLE states SHALL be ignored; the command is not lost (cmd_ready=0).

Reset
REQ-031 On ARESETn=0 at an edge: state IDLE; AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid = 0; AWADDR, ARADDR, WDATA, rsp_rdata = 0; WSTRB, rsp_resp = 0; rsp_write = 0; cmd_ready = 0 while reset held, 1 the first cycle after release.
REQ-032 Reset mid-transaction SHALL abort it: all VALID/READY outputs low on the reset edge; no completion is reported.

Verification
REQ-033 Write 0x0000_0000 <- 0xA5A5A5A5, wstrb 0xF, zero-wait slave -> one AW and one W handshake with those values, BREADY high, rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0.
REQ-034 Read 0x0000_0004 with slave RDATA=0xDEADBEEF, RRESP=0, ARREADY delayed 3 cycles -> ARADDR stable 4 cycles, rsp_rdata=0xDEADBEEF, rsp_write=0.
REQ-035 Write with AWREADY at cycle 1, WREADY at cycle 4 (and reverse) -> each VALID drops after its own handshake, exactly one B accepted.
REQ-036 Slave returns BRESP=2'b10 / RRESP=2'b11 -> rsp_resp = 2'b10 / 2'b11.
REQ-037 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, no new AXI VALID until rsp consumed.
REQ-038 ARESETn=0 during WR_RESP -> all AXI outputs 0 on that edge, rsp_valid never asserts, cmd_ready=1 first cycle after release.
